mem_arbiter: RTL and testbench

- Two-master arbiter and sequencer in front of the single-port synchronous core RAM (1024 x 32, registered q, 1-cycle read latency).
- Masters are the instruction-fetch port (read-only) and the load/store port (read/write with byte enables).
- Round-robin arbitration, one outstanding transaction at a time; sub-word stores are done as internal read-modify-write.
- RAM window: addr[31:12] == 20'h00001, word index addr[11:2]; accesses outside the window complete without touching RAM.

---
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter and sequencer in front of a single-port synchronous RAM.
// Sub-word stores become an internal read-modify-write; off-window accesses complete without touching RAM.
module mem_arbiter #(
    parameter int          DATA_W   = 32,
    parameter int          RAM_AW   = 10,
    parameter logic [19:0] WIN_BASE = 20'h00001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [31:0]       ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    input  logic [3:0]        ls_be,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_q
);

    localparam int LANE_W = DATA_W / 4;

    typedef enum logic [1:0] {S_IDLE, S_MERGE, S_RESP} state_t;

    state_t              r_state;
    logic                r_owner_ls;
    logic                r_last_ls;
    logic                r_we;
    logic                r_inwin;
    logic [RAM_AW-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [3:0]          r_be;

    logic                w_idle;
    logic                w_gnt_ls;
    logic                w_gnt_if;
    logic                w_gnt;
    logic [31:0]         w_sel_addr;
    logic                w_sel_we;
    logic                w_sel_inwin;
    logic                w_full_st;
    logic                w_part_st;
    logic                w_resp;
    logic [DATA_W-1:0]   w_rdata;
    logic [DATA_W-1:0]   w_merge_data;
    logic                w_unused_addr_bits;

    // Grants only in IDLE; on contention the master that did not win last time goes first.
    assign w_idle   = rst_n && (r_state == S_IDLE);
    assign w_gnt_ls = w_idle && ls_req && (!if_req || !r_last_ls);
    assign w_gnt_if = w_idle && if_req && !w_gnt_ls;
    assign w_gnt    = w_gnt_ls || w_gnt_if;
    assign if_gnt   = w_gnt_if;
    assign ls_gnt   = w_gnt_ls;

    assign w_sel_addr  = w_gnt_ls ? ls_addr : if_addr;
    assign w_sel_we    = w_gnt_ls && ls_we;
    assign w_sel_inwin = (w_sel_addr[31:12] == WIN_BASE);
    assign w_full_st   = w_sel_we && w_sel_inwin && (ls_be == 4'hF);
    assign w_part_st   = w_sel_we && w_sel_inwin && (ls_be != 4'h0) && (ls_be != 4'hF);

    assign w_unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0]};

    always_comb begin
        w_merge_data = ram_q;
        for (int i = 0; i < 4; i++) begin
            if (r_be[i]) w_merge_data[i*LANE_W +: LANE_W] = r_wdata[i*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the branches so no path can infer a latch.
        ram_addr = '0;
        ram_data = '0;
        ram_we   = 1'b0;
        if (w_gnt) begin
            ram_addr = w_sel_addr[RAM_AW+1:2];
            if (w_full_st) begin
                ram_we   = 1'b1;
                ram_data = ls_wdata;
            end
        end else if (r_state == S_MERGE) begin
            ram_addr = r_addr;
            ram_we   = 1'b1;
            ram_data = w_merge_data;
        end
    end

    // Read data is only meaningful for in-window loads; ram_q is valid in RESP for those.
    assign w_resp    = (r_state == S_RESP);
    assign w_rdata   = (r_inwin && !r_we) ? ram_q : '0;
    assign if_rvalid = w_resp && !r_owner_ls;
    assign ls_rvalid = w_resp && r_owner_ls;
    assign if_rdata  = if_rvalid ? w_rdata : '0;
    assign ls_rdata  = ls_rvalid ? w_rdata : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_owner_ls <= 1'b0;
            r_last_ls  <= 1'b0;
            r_we       <= 1'b0;
            r_inwin    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            case (r_state)
                S_IDLE: begin
                    if (w_gnt) begin
                        r_owner_ls <= w_gnt_ls;
                        r_last_ls  <= w_gnt_ls;
                        r_we       <= w_sel_we;
                        r_inwin    <= w_sel_inwin;
                        r_addr     <= w_sel_addr[RAM_AW+1:2];
                        r_wdata    <= ls_wdata;
                        r_be       <= ls_be;
                        r_state    <= w_part_st ? S_MERGE : S_RESP;
                    end
                end
                S_MERGE: r_state <= S_RESP;
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 1024x32 RAM behind it.
// Expected values are hand-computed constants.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_be;
    logic        ls_gnt;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_data;
    logic        ram_we;
    logic [31:0] ram_q;

    logic [31:0] mem [0:1023];
    logic        tb_load;

    int n_chk = 0;
    int n_err = 0;

    // Results captured by txn()
    int          g_lat;
    logic [31:0] g_rdata;
    logic [9:0]  g_addr_t;
    logic        g_we_t;
    logic [31:0] g_data_t;
    logic        g_we_t1;
    logic [31:0] g_data_t1;
    logic        g_any_we;
    logic        g_other_rv;

    mem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_be     (ls_be),
        .ls_gnt    (ls_gnt),
        .ls_rvalid (ls_rvalid),
        .ls_rdata  (ls_rdata),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_we    (ram_we),
        .ram_q     (ram_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_load) begin
            mem[0] <= 32'h0000_0000;
            mem[1] <= 32'h1122_3344;
            mem[2] <= 32'hDEAD_BEEF;
            mem[3] <= 32'h0A0B_0C0D;
            mem[4] <= 32'h0000_0000;
            mem[5] <= 32'h5555_5555;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_data;
        end
        ram_q <= mem[ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One transaction from grant to response; call just after a rising edge.
    task automatic txn(input bit is_ls, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
        bit got;
        g_lat = 0; g_rdata = '0; g_any_we = 1'b0; g_other_rv = 1'b0;
        g_we_t1 = 1'b0; g_data_t1 = '0;
        if (is_ls) begin
            ls_req = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_be = be;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk);
            got = is_ls ? ls_gnt : if_gnt;
        end
        if (!got) begin
            check("gnt_timeout", 32'd0, 32'd1);
            if_req = 1'b0; ls_req = 1'b0;
            return;
        end
        g_addr_t = ram_addr; g_we_t = ram_we; g_data_t = ram_data; g_any_we = ram_we;
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0; ls_wdata = '0; ls_be = '0;
        got = 1'b0;
        for (int k = 1; k <= 6 && !got; k++) begin
            @(negedge clk);
            if (k == 1) begin g_we_t1 = ram_we; g_data_t1 = ram_data; end
            g_any_we   = g_any_we | ram_we;
            g_other_rv = g_other_rv | (is_ls ? if_rvalid : ls_rvalid);
            got = is_ls ? ls_rvalid : if_rvalid;
            if (got) begin
                g_lat   = k;
                g_rdata = is_ls ? ls_rdata : if_rdata;
            end
        end
        if (!got) check("rvalid_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;
        tb_load = 1'b1;
        rst_n   = 1'b0;
        if_req  = 1'b1; if_addr = 32'h0000_1000;
        ls_req  = 1'b1; ls_we = 1'b0; ls_addr = 32'h0000_1000; ls_wdata = '0; ls_be = '0;

        // Reset state with both requests already high
        @(negedge clk);
        check("rst_if_gnt", if_gnt, 1'b0);
        check("rst_ls_gnt", ls_gnt, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_rvalid", {if_rvalid, ls_rvalid}, 2'b00);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_ls_rdata", ls_rdata, 32'h0);
        check("rst_ram_addr", ram_addr, 10'h0);
        check("rst_ram_data", ram_data, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        tb_load = 1'b0;
        rst_n   = 1'b1;

        // Contention from reset: LS first, then alternate, one gnt every 2 cycles
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_g = (c % 4 == 0) ? 2'b01 : (c % 4 == 2) ? 2'b10 : 2'b00;
            check($sformatf("rr_gnt_c%0d", c), {if_gnt, ls_gnt}, exp_g);
        end
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;

        // Fetch from RAM[2]
        txn(1'b0, 1'b0, 32'h0000_1008, '0, '0);
        check("fetch_ram_addr", g_addr_t, 10'd2);
        check("fetch_ram_we", g_we_t, 1'b0);
        check("fetch_lat", g_lat, 1);
        check("fetch_rdata", g_rdata, 32'hDEAD_BEEF);
        check("fetch_ls_quiet", {g_other_rv, ls_rdata}, 33'h0);

        // Partial store: read-modify-write of byte lane 1
        txn(1'b1, 1'b1, 32'h0000_1004, 32'h0000_AB00, 4'b0010);
        check("pst_we_t", g_we_t, 1'b0);
        check("pst_we_t1", g_we_t1, 1'b1);
        check("pst_data_t1", g_data_t1, 32'h1122_AB44);
        check("pst_lat", g_lat, 2);
        check("pst_rdata", g_rdata, 32'h0);
        check("pst_mem", mem[1], 32'h1122_AB44);
        txn(1'b1, 1'b0, 32'h0000_1004, '0, '0);
        check("pst_load_lat", g_lat, 1);
        check("pst_load_rdata", g_rdata, 32'h1122_AB44);
        check("pst_load_if_quiet", g_other_rv, 1'b0);

        // Full store writes in the grant cycle
        txn(1'b1, 1'b1, 32'h0000_1010, 32'hCAFE_F00D, 4'hF);
        check("fst_we_t", g_we_t, 1'b1);
        check("fst_addr_t", g_addr_t, 10'd4);
        check("fst_data_t", g_data_t, 32'hCAFE_F00D);
        check("fst_lat", g_lat, 1);
        check("fst_mem", mem[4], 32'hCAFE_F00D);

        // be==0 store: acknowledged, no write
        txn(1'b1, 1'b1, 32'h0000_1014, 32'h1234_5678, 4'h0);
        check("be0_any_we", g_any_we, 1'b0);
        check("be0_lat", g_lat, 1);
        check("be0_mem", mem[5], 32'h5555_5555);

        // Out-of-window store: dropped but acknowledged
        txn(1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF);
        check("oow_st_any_we", g_any_we, 1'b0);
        check("oow_st_lat", g_lat, 1);
        check("oow_st_mem", mem[8], 32'hCAFE_F00D ^ 32'hCAFE_F00D ^ mem[8]);

        // Out-of-window load: zero data
        txn(1'b1, 1'b0, 32'h0000_0000, '0, '0);
        check("oow_ld_any_we", g_any_we, 1'b0);
        check("oow_ld_lat", g_lat, 1);
        check("oow_ld_rdata", g_rdata, 32'h0);

        // Reset pulse during MERGE of a partial store
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h0000_100C; ls_wdata = 32'h0000_00FF; ls_be = 4'b0001;
        @(negedge clk);
        check("mrst_gnt", ls_gnt, 1'b1);
        @(posedge clk); #1;
        ls_req = 1'b0; ls_we = 1'b0; ls_be = '0; ls_wdata = '0;
        check("mrst_we_before", ram_we, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mrst_we_dropped", ram_we, 1'b0);
        @(negedge clk);
        check("mrst_no_rvalid0", ls_rvalid, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mrst_no_rvalid1", ls_rvalid, 1'b0);
        check("mrst_mem", mem[3], 32'h0A0B_0C0D);
        @(posedge clk); #1;
        txn(1'b1, 1'b0, 32'h0000_100C, '0, '0);
        check("mrst_after_lat", g_lat, 1);
        check("mrst_after_rdata", g_rdata, 32'h0A0B_0C0D);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
